// File: rtl/amns_pkg.sv
// Shared constants and types for the AMNS word-serial FIOS result path.
package amns_pkg;

  localparam int WORD_WIDTH = 17;
  localparam int N          = 5;
  localparam int S          = 4;
  localparam int COEF_W     = S * WORD_WIDTH;
  localparam int POLY_W     = N * COEF_W;

  typedef logic [WORD_WIDTH:0]       word_t;
  typedef logic signed [COEF_W-1:0]  coef_t;
  typedef logic [POLY_W-1:0]         poly_t;

endpackage

// File: rtl/fios_carry_norm.sv
// Folds the redundant carry bit of each stream word into the next word of the
// same coefficient; the carry out of a coefficient's top word is discarded.
module fios_carry_norm
  import amns_pkg::*;
#(
  parameter int WW = WORD_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          word_valid,
  input  logic          last_word,
  input  logic [WW:0]   word_in,
  output logic [WW-1:0] norm_word
);

  logic [1:0]    carry_reg;
  logic [WW+1:0] sum;

  // Redundant word plus pending carry; the carry can reach 2, hence WW+2 bits.
  assign sum       = {1'b0, word_in} + {{WW{1'b0}}, carry_reg};
  assign norm_word = sum[WW-1:0];

  // Carry register: restarts at zero at every coefficient boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg <= 2'd0;
    end else if (word_valid) begin
      carry_reg <= last_word ? 2'd0 : sum[WW+1:WW];
    end
  end

endmodule

// File: rtl/poly_fios_result_collector.sv
// Collects the normalised FIOS output stream into N signed coefficients and
// presents whole polynomials through two ping-pong banks on a valid/ready port.
module poly_fios_result_collector
  import amns_pkg::*;
#(
  parameter int WW  = WORD_WIDTH,
  parameter int NC  = N,
  parameter int SW  = S
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               word_valid_i,
  input  logic [WW:0]        word_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [NC*SW*WW-1:0] res_poly_o,
  output logic               overflow_o
);

  localparam int SLOTS  = NC * SW;
  localparam int WIDX_W = (SW > 1) ? $clog2(SW) : 1;
  localparam int CIDX_W = (NC > 1) ? $clog2(NC) : 1;

  logic [WIDX_W-1:0] word_idx_reg;
  logic [CIDX_W-1:0] coef_idx_reg;
  logic [1:0]        full_cnt_reg;
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic              drop_reg;
  logic              overflow_reg;
  logic [WW-1:0]     bank_reg [2][SLOTS];

  logic              last_word;
  logic              last_coef;
  logic              first_word;
  logic              drop_now;
  logic              poly_done;
  logic              handshake;
  logic [WW-1:0]     norm_word;
  logic [SLOTS-1:0]  slot_hit;

  assign last_word  = (word_idx_reg == WIDX_W'(SW - 1));
  assign last_coef  = (coef_idx_reg == CIDX_W'(NC - 1));
  assign first_word = (word_idx_reg == '0) && (coef_idx_reg == '0);
  // The drop decision is taken on the first word and held for the whole polynomial.
  assign drop_now   = first_word ? (full_cnt_reg == 2'd2) : drop_reg;
  assign poly_done  = word_valid_i && last_word && last_coef && !drop_now;
  assign res_valid_o = (full_cnt_reg != 2'd0);
  assign handshake  = res_valid_o && res_ready_i;
  assign overflow_o = overflow_reg;

  fios_carry_norm #(.WW(WW)) u_carry_norm (
    .clk        (clock_i),
    .rst_n      (reset_n_i),
    .word_valid (word_valid_i),
    .last_word  (last_word),
    .word_in    (word_i),
    .norm_word  (norm_word)
  );

  // Slot decode and output mux: slot gi holds word gi%SW of coefficient gi/SW.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign slot_hit[gi] = (coef_idx_reg == CIDX_W'(gi / SW)) &&
                          (word_idx_reg == WIDX_W'(gi % SW));
    assign res_poly_o[gi*WW +: WW] = bank_reg[rd_ptr_reg][gi];
  end

  // Stream position counters, per-polynomial drop flag and sticky overflow.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_idx_reg <= '0;
      coef_idx_reg <= '0;
      drop_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (word_valid_i) begin
      drop_reg <= drop_now;
      if (drop_now) begin
        overflow_reg <= 1'b1;
      end
      if (last_word) begin
        word_idx_reg <= '0;
        coef_idx_reg <= last_coef ? '0 : coef_idx_reg + CIDX_W'(1);
      end else begin
        word_idx_reg <= word_idx_reg + WIDX_W'(1);
      end
    end
  end

  // Bank occupancy and ping-pong pointers; completion and drain may coincide.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_cnt_reg <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      case ({poly_done, handshake})
        2'b10:   full_cnt_reg <= full_cnt_reg + 2'd1;
        2'b01:   full_cnt_reg <= full_cnt_reg - 2'd1;
        default: full_cnt_reg <= full_cnt_reg;
      endcase
      if (poly_done) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (handshake) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  // Result banks: each accepted, non-dropped word lands in its slot of the write bank.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < SLOTS; s++) begin
          bank_reg[b][s] <= '0;
        end
      end
    end else if (word_valid_i && !drop_now) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_hit[s]) begin
          bank_reg[wr_ptr_reg][s] <= norm_word;
        end
      end
    end
  end

endmodule
